// File: rtl/mem_block_arbiter.sv
// Arbiter sharing one memory port between a writer and a reader across two
// memory blocks. A single FSM serves one access at a time. When both sides
// ask at once, the side that was not served last goes first.
//
// Handshake: a requester raises its req with address/data stable and holds it
// until the matching one-cycle completion pulse (wr_ack or rd_valid) appears.
// The arbiter latches the request when it leaves IDLE, so the access finishes
// even if req drops early. Block selects (switch0/switch1) are sampled only at
// grant time.
module mem_block_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              switch0,
    input  logic              switch1,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata0,
    input  logic [DATA_W-1:0] mem_rdata1,
    output logic              busy,
    output logic              last_wr_blk,
    output logic              last_rd_blk,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        RDWAIT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Access context captured at grant time.
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;

    // 1 = the writer was served most recently; reset favours the writer.
    logic              last_grant_wr;

    logic              grant_wr;
    logic              grant_rd;
    logic [DATA_W-1:0] rdata_sel;

    // Grant decision in IDLE: round-robin only matters on a tie.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == IDLE) begin
            grant_wr = wr_req && (!rd_req || !last_grant_wr);
            grant_rd = rd_req && !grant_wr;
        end
    end

    // Read data returned by the block chosen at grant time.
    always_comb begin
        rdata_sel = sel_q ? mem_rdata1 : mem_rdata0;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state memory strobes / completion pulses.
    always_comb begin
        state_nxt = state;
        mem_en    = 2'b00;
        mem_we    = 1'b0;
        wr_ack    = 1'b0;
        rd_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt = WRITE;
                end else if (grant_rd) begin
                    state_nxt = READ;
                end
            end
            WRITE: begin
                mem_en    = sel_q ? 2'b10 : 2'b01;
                mem_we    = 1'b1;
                wr_ack    = 1'b1;
                state_nxt = IDLE;
            end
            READ: begin
                mem_en    = sel_q ? 2'b10 : 2'b01;
                state_nxt = RDWAIT;
            end
            RDWAIT: begin
                rd_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the granted request's block select, address and write data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_wr) begin
            sel_q   <= switch0;
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
        end else if (grant_rd) begin
            sel_q   <= switch1;
            addr_q  <= rd_addr;
        end
    end

    // Hold the last read result so rd_data stays stable between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (state == RDWAIT) begin
            rd_data_q <= rdata_sel;
        end
    end

    // Completion bookkeeping: display blocks and round-robin history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_wr_blk   <= 1'b0;
            last_rd_blk   <= 1'b0;
            last_grant_wr <= 1'b0;
        end else if (state == WRITE) begin
            last_wr_blk   <= sel_q;
            last_grant_wr <= 1'b1;
        end else if (state == RDWAIT) begin
            last_rd_blk   <= sel_q;
            last_grant_wr <= 1'b0;
        end
    end

    // rd_data shows the fresh block data in the rd_valid cycle itself.
    always_comb begin
        rd_data = (state == RDWAIT) ? rdata_sel : rd_data_q;
    end

    // Shared buses and status.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state != IDLE);
        state_dbg = state;
    end

`ifndef SYNTHESIS
    // Protocol invariants on the outputs.
    always @(posedge clock) begin
        if (!reset) begin
            assert (mem_en != 2'b11)
                else $error("mem_en has both blocks enabled");
            assert (!(wr_ack && rd_valid))
                else $error("wr_ack and rd_valid high together");
        end
    end
`endif

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter: a table of single accesses followed
// by hand-written sequences for switch changes, early request drop, tie
// arbitration from reset and reset during a read.
module tb_mem_block_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clock;
    logic              reset;
    logic              switch0;
    logic              switch1;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata0;
    logic [DATA_W-1:0] mem_rdata1;
    logic              busy;
    logic              last_wr_blk;
    logic              last_rd_blk;
    logic [1:0]        state_dbg;

    mem_block_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .switch0     (switch0),
        .switch1     (switch1),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata0  (mem_rdata0),
        .mem_rdata1  (mem_rdata1),
        .busy        (busy),
        .last_wr_blk (last_wr_blk),
        .last_rd_blk (last_rd_blk),
        .state_dbg   (state_dbg)
    );

    // Clock and watchdog.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard.
    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              is_wr;
        logic              sw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
        logic [1:0]        exp_en;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // Driver: one complete access starting from IDLE at a falling edge.
    task automatic do_vec(input vec_t v);
        logic [DATA_W-1:0] exp_rd;
        if (v.is_wr) begin
            switch0 = v.sw;
            wr_addr = v.addr;
            wr_data = v.wdata;
            wr_req  = 1'b1;
            @(negedge clock);
            check("wr_mem_en", 32'(mem_en), 32'(v.exp_en));
            check("wr_mem_we", 32'(mem_we), 32'd1);
            check("wr_mem_addr", 32'(mem_addr), 32'(v.addr));
            check("wr_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
            check("wr_ack", 32'(wr_ack), 32'd1);
            check("wr_no_rd_valid", 32'(rd_valid), 32'd0);
            check("wr_busy", 32'(busy), 32'd1);
            wr_req = 1'b0;
            @(negedge clock);
            check("wr_ack_drop", 32'(wr_ack), 32'd0);
            check("wr_idle_en", 32'(mem_en), 32'd0);
            check("last_wr_blk", 32'(last_wr_blk), 32'(v.sw));
            check("wr_idle_busy", 32'(busy), 32'd0);
        end else begin
            switch1    = v.sw;
            rd_addr    = v.addr;
            mem_rdata0 = v.rd0;
            mem_rdata1 = v.rd1;
            rd_req     = 1'b1;
            exp_q.push_back(v.exp_rdata);
            @(negedge clock);
            check("rd_mem_en", 32'(mem_en), 32'(v.exp_en));
            check("rd_mem_we", 32'(mem_we), 32'd0);
            check("rd_mem_addr", 32'(mem_addr), 32'(v.addr));
            check("rd_valid_early", 32'(rd_valid), 32'd0);
            @(negedge clock);
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_wait_en", 32'(mem_en), 32'd0);
            exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("rd_data", 32'(rd_data), 32'(exp_rd));
            rd_req = 1'b0;
            @(negedge clock);
            check("rd_valid_drop", 32'(rd_valid), 32'd0);
            check("rd_data_hold", 32'(rd_data), 32'(v.exp_rdata));
            check("last_rd_blk", 32'(last_rd_blk), 32'(v.sw));
        end
    endtask

    // Main test.
    initial begin
        int ev_count;
        logic [DATA_W-1:0] ev_exp;

        reset = 1'b1;
        switch0 = 1'b0; switch1 = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        mem_rdata0 = '0; mem_rdata1 = '0;

        // Vector table: op, switch, addr, wdata, rdata0, rdata1, exp mem_en, exp rd_data.
        vecs[0] = '{1'b1, 1'b1, 4'h3, 8'hA5, 8'h00, 8'h00, 2'b10, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'h5A, 8'hC3, 2'b01, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 8'h3C, 8'h00, 8'h00, 2'b01, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 4'h0, 8'h00, 8'h11, 8'hEE, 2'b10, 8'hEE};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 8'hFF, 8'h00, 8'h00, 2'b10, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 4'hA, 8'h00, 8'h00, 8'h80, 2'b10, 8'h80};
        vecs[6] = '{1'b0, 1'b0, 4'h5, 8'h00, 8'h7F, 8'h01, 2'b01, 8'h7F};

        // Reset values.
        repeat (2) @(negedge clock);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last_wr", 32'(last_wr_blk), 32'd0);
        check("rst_last_rd", 32'(last_rd_blk), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_vec(vecs[i]);
        end

        // Switch toggled during RDWAIT: data still from block 2.
        switch1 = 1'b1; rd_addr = 4'h7;
        mem_rdata0 = 8'hCD; mem_rdata1 = 8'hAB;
        rd_req = 1'b1;
        @(negedge clock);
        check("sw_rd_mem_en", 32'(mem_en), 32'b10);
        @(posedge clock);
        #1 switch1 = 1'b0;
        @(negedge clock);
        check("sw_rd_valid", 32'(rd_valid), 32'd1);
        check("sw_rd_data", 32'(rd_data), 32'hAB);
        rd_req = 1'b0;
        @(negedge clock);
        check("sw_last_rd", 32'(last_rd_blk), 32'd1);

        // Requests dropped right after grant still complete.
        switch0 = 1'b0; wr_addr = 4'h6; wr_data = 8'h99; wr_req = 1'b1;
        @(posedge clock);
        #1 wr_req = 1'b0;
        @(negedge clock);
        check("drop_wr_ack", 32'(wr_ack), 32'd1);
        check("drop_wr_en", 32'(mem_en), 32'b01);
        @(negedge clock);
        switch1 = 1'b0; rd_addr = 4'h2; mem_rdata0 = 8'h42; rd_req = 1'b1;
        @(posedge clock);
        #1 rd_req = 1'b0;
        @(negedge clock);
        check("drop_rd_en", 32'(mem_en), 32'b01);
        @(negedge clock);
        check("drop_rd_valid", 32'(rd_valid), 32'd1);
        check("drop_rd_data", 32'(rd_data), 32'h42);
        @(negedge clock);

        // Both requests held high from reset: write, read, write, read.
        reset = 1'b1;
        #1;
        switch0 = 1'b1; switch1 = 1'b0;
        wr_addr = 4'h1; wr_data = 8'h10;
        rd_addr = 4'h4; mem_rdata0 = 8'h21; mem_rdata1 = 8'h43;
        wr_req = 1'b1; rd_req = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        ev_count = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("tie_no_overlap", 32'(wr_ack && rd_valid), 32'd0);
            if (wr_ack || rd_valid) begin
                ev_count++;
                ev_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                check("tie_order", wr_ack ? 32'h01 : 32'h02, 32'(ev_exp));
                if (rd_valid) check("tie_rd_data", 32'(rd_data), 32'h21);
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check("tie_events", 32'(ev_count), 32'd4);
        @(negedge clock);

        // Reset during READ aborts the access.
        switch1 = 1'b1; rd_addr = 4'h9; mem_rdata1 = 8'h77; rd_req = 1'b1;
        @(negedge clock);
        check("abort_pre_en", 32'(mem_en), 32'b10);
        check("abort_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_wr_ack", 32'(wr_ack), 32'd0);
        check("abort_rd_data", 32'(rd_data), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        check("abort_last_wr", 32'(last_wr_blk), 32'd0);
        check("abort_last_rd", 32'(last_rd_blk), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        rd_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_no_valid", 32'(rd_valid), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        // First access after reset is accepted on the next edge.
        do_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_block_arbiter.md
MEM_BLOCK_ARBITER -- requirements
Module: mem_block_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, memory word-address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 clock  input  1  single clock for all state; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately, independent of clock.
REQ-005 switch0  input  1  write-block select: 0 = block 1, 1 = block 2.
REQ-006 switch1  input  1  read-block select: 0 = block 1, 1 = block 2.
REQ-007 wr_req  input  1  writer requests one write; held high until wr_ack.
REQ-008 wr_addr  input  ADDR_W  write address; stable while wr_req is high.
REQ-009 wr_data  input  DATA_W  write data; stable while wr_req is high.
REQ-010 wr_ack  output  1  one-cycle pulse: the write has been performed.
REQ-011 rd_req  input  1  reader requests one read; held high until rd_valid.
REQ-012 rd_addr  input  ADDR_W  read address; stable while rd_req is high.
REQ-013 rd_data  output  DATA_W  read result; holds its value until the next rd_valid.
REQ-014 rd_valid  output  1  one-cycle pulse: rd_data is updated this cycle.
REQ-015 mem_en  output  2  block enables; bit0 = block 1, bit1 = block 2; at most one bit high in any cycle.
REQ-016 mem_we  output  1  write strobe for the enabled block.
REQ-017 mem_addr  output  ADDR_W  shared address bus to both blocks.
REQ-018 mem_wdata  output  DATA_W  shared write-data bus to both blocks.
REQ-019 mem_rdata0 / mem_rdata1  input  DATA_W each  block 1 / block 2 read data, valid one cycle after the enabled read.
REQ-020 busy  output  1  high whenever the FSM is not in IDLE.
REQ-021 last_wr_blk / last_rd_blk  output  1 each  block used by the most recent completed write / read (0 = block 1), for the segment display.

Function
REQ-022 The FSM SHALL have the states IDLE, WRITE, READ and RDWAIT, and no others.
REQ-023 In IDLE with only wr_req high, the FSM SHALL go to WRITE and latch sel = switch0, wr_addr and wr_data.
REQ-024 In IDLE with only rd_req high, the FSM SHALL go to READ and latch sel = switch1 and rd_addr.
REQ-025 In IDLE with both requests high, the FSM SHALL grant the requester that was not served last (round-robin bit last_grant, reset value = reader, so the writer wins the first tie).
REQ-026 In WRITE, the block SHALL drive mem_en[sel] = 1, mem_we = 1, the latched address/data, and pulse wr_ack; it SHALL then set last_wr_blk = sel and last_grant = writer, and return to IDLE.
REQ-027 In READ, the block SHALL drive mem_en[sel] = 1, mem_we = 0 and the latched address, then go to RDWAIT.
REQ-028 In RDWAIT, the block SHALL capture rd_data from mem_rdata0 or mem_rdata1 according to sel, pulse rd_valid, set last_rd_blk = sel and last_grant = reader, and return to IDLE.
REQ-029 Latency SHALL be: write grant to wr_ack = 1 cycle after leaving IDLE; read grant to rd_valid = 2 cycles after leaving IDLE; minimum spacing between accepted requests = 2 cycles for writes and 3 cycles for reads.
REQ-030 Switch changes SHALL affect only requests accepted afterwards; an in-flight access uses the latched sel.
REQ-031 Outside WRITE and READ, mem_en SHALL be 2'b00 and mem_we SHALL be 0.
REQ-032 A request deasserted before its ack/valid is a protocol violation; the in-flight access SHALL still complete normally.
REQ-033 wr_ack and rd_valid SHALL never be high in the same cycle.

Reset
REQ-034 On reset: state = IDLE; mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; wr_ack = 0, rd_valid = 0, rd_data = 0; busy = 0; last_wr_blk = 0, last_rd_blk = 0; last_grant = reader.
REQ-035 Reset asserted mid-access SHALL abort the access with no ack/valid pulse; after release, the FSM SHALL accept new requests from IDLE on the first clock edge.

Verification
REQ-036 switch0=1, wr_req with addr 3, data 8'hA5 -> next cycle mem_en=2'b10, mem_we=1, mem_addr=3, mem_wdata=A5, wr_ack=1; then last_wr_blk=1.
REQ-037 switch1=0, rd_req addr 3, mem_rdata0=8'h5A -> mem_en=2'b01 one cycle, then rd_valid=1 with rd_data=5A; last_rd_blk=0.
REQ-038 wr_req and rd_req held high together from reset -> grant order write, read, write, read; wr_ack and rd_valid never coincide.
REQ-039 switch1 toggled during RDWAIT -> rd_data still taken from the block latched at grant.
REQ-040 reset pulsed while in READ -> mem_en=0 immediately, no rd_valid, busy=0, all outputs at REQ-034 values.
